// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser serial-to-parallel deserialiser.
// Optional parity framing is enabled with the SIPO_PARITY_EN macro.
package sipo_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

`ifdef SIPO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic logic even_parity(input logic [64:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// Single-entry output holding register with valid/ready handshake and a
// one-cycle overrun pulse when a new word arrives while the old one is stuck.
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data_q,
    output logic             valid_q,
    output logic             overrun_q
);

    buf_state_e       state_r;
    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             overrun_r;

    // EMPTY/FULL state machine; a word completing while FULL and unconsumed is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= EMPTY;
            data_r    <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            case (state_r)
                EMPTY: begin
                    if (load) begin
                        data_r  <= load_data;
                        valid_r <= 1'b1;
                        state_r <= FULL;
                    end
                end
                FULL: begin
                    if (load && ready) begin
                        data_r <= load_data;
                    end else if (load) begin
                        overrun_r <= 1'b1;
                    end else if (ready) begin
                        valid_r <= 1'b0;
                        state_r <= EMPTY;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= EMPTY;
                end
            endcase
        end
    end

    assign data_q    = data_r;
    assign valid_q   = valid_r;
    assign overrun_q = overrun_r;

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-in/parallel-out deserialiser with bit-order select and
// registered output handshake. Define SIPO_PARITY_EN for a trailing even-parity bit.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      serial_in,
    input  logic                      serial_valid,
    input  logic                      clear,
    output logic [WIDTH-1:0]          parallel_out,
    output logic                      parallel_valid,
    input  logic                      parallel_ready,
    output logic                      overrun,
`ifdef SIPO_PARITY_EN
    output logic                      parity_err,
`endif
    output logic [cnt_w(WIDTH)-1:0]   bit_count
);

    localparam int CNT_W     = cnt_w(WIDTH);
    localparam int FRAME_LEN = WIDTH + PARITY_BITS;
    localparam int ICNT_W    = cnt_w(FRAME_LEN);
    localparam logic [ICNT_W-1:0] LAST_IDX = ICNT_W'(FRAME_LEN - 1);
`ifdef SIPO_PARITY_EN
    localparam logic [ICNT_W-1:0] DATA_LAST = ICNT_W'(WIDTH - 1);
`endif

    logic [WIDTH-1:0]     shreg_r;
    logic [WIDTH-1:0]     shreg_next_s;
    logic [WIDTH-1:0]     shreg_d_s;
    logic [ICNT_W-1:0]    cnt_r;
    logic [ICNT_W-1:0]    cnt_next_s;
    logic [CNT_W-1:0]     bit_count_r;
    logic [CNT_W-1:0]     bit_count_next_s;
    logic                 shift_s;
    logic                 complete_s;
    logic [FRAME_LEN-1:0] word_s;
    logic [FRAME_LEN-1:0] buf_q_s;

    // Next shift-register/counter values and frame completion detect
    always_comb begin
        shreg_next_s     = shreg_r;
        shreg_d_s        = shreg_r;
        cnt_next_s       = cnt_r;
        complete_s       = 1'b0;
        bit_count_next_s = '0;

        if (LSB_FIRST) begin
            shreg_next_s = {serial_in, shreg_r[WIDTH-1:1]};
        end else begin
            shreg_next_s = {shreg_r[WIDTH-2:0], serial_in};
        end

`ifdef SIPO_PARITY_EN
        // the parity bit is checked but never enters the data word
        shift_s = serial_valid && !clear && (cnt_r != LAST_IDX);
        word_s  = {even_parity(65'({serial_in, shreg_r})), shreg_r};
`else
        shift_s = serial_valid && !clear;
        word_s  = shreg_next_s;
`endif

        if (clear) begin
            shreg_d_s  = '0;
            cnt_next_s = '0;
        end else if (serial_valid) begin
            if (shift_s) begin
                shreg_d_s = shreg_next_s;
            end else begin
                shreg_d_s = shreg_r;
            end
            if (cnt_r == LAST_IDX) begin
                cnt_next_s = '0;
                complete_s = 1'b1;
            end else begin
                cnt_next_s = cnt_r + ICNT_W'(1);
            end
        end else begin
            shreg_d_s  = shreg_r;
            cnt_next_s = cnt_r;
        end

`ifdef SIPO_PARITY_EN
        if (cnt_next_s > DATA_LAST) begin
            bit_count_next_s = CNT_W'(WIDTH - 1);
        end else begin
            bit_count_next_s = cnt_next_s[CNT_W-1:0];
        end
`else
        bit_count_next_s = cnt_next_s;
`endif
    end

    // Shift register and frame bit counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_r     <= '0;
            cnt_r       <= '0;
            bit_count_r <= '0;
        end else begin
            shreg_r     <= shreg_d_s;
            cnt_r       <= cnt_next_s;
            bit_count_r <= bit_count_next_s;
        end
    end

    sipo_out_buf #(
        .WIDTH (FRAME_LEN)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst),
        .load      (complete_s),
        .load_data (word_s),
        .ready     (parallel_ready),
        .data_q    (buf_q_s),
        .valid_q   (parallel_valid),
        .overrun_q (overrun)
    );

    assign parallel_out = buf_q_s[WIDTH-1:0];
    assign bit_count    = bit_count_r;
`ifdef SIPO_PARITY_EN
    assign parity_err   = buf_q_s[WIDTH];
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser (4-bit MSB, 4-bit LSB and 8-bit MSB
// instances sharing one stimulus stream). Honours SIPO_PARITY_EN when defined.
module tb_sipo_deser;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic       serial_valid;
    logic       clear;
    logic       parallel_ready;

    logic [3:0] out4;
    logic       valid4;
    logic       ovr4;
    logic [1:0] bc4;
    logic [3:0] out4l;
    logic       valid4l;
    logic       ovr4l;
    logic [1:0] bc4l;
    logic [7:0] out8;
    logic       valid8;
    logic       ovr8;
    logic [2:0] bc8;
`ifdef SIPO_PARITY_EN
    logic       perr4;
    logic       perr4l;
    logic       perr8;
`endif

    int n_checks = 0;
    int n_errors = 0;

    sipo_deser #(.WIDTH(4), .LSB_FIRST(1'b0)) u_dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
        .clear(clear), .parallel_out(out4), .parallel_valid(valid4),
        .parallel_ready(parallel_ready), .overrun(ovr4),
`ifdef SIPO_PARITY_EN
        .parity_err(perr4),
`endif
        .bit_count(bc4)
    );

    sipo_deser #(.WIDTH(4), .LSB_FIRST(1'b1)) u_dut_lsb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
        .clear(clear), .parallel_out(out4l), .parallel_valid(valid4l),
        .parallel_ready(parallel_ready), .overrun(ovr4l),
`ifdef SIPO_PARITY_EN
        .parity_err(perr4l),
`endif
        .bit_count(bc4l)
    );

    sipo_deser #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut8 (
        .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
        .clear(clear), .parallel_out(out8), .parallel_valid(valid8),
        .parallel_ready(parallel_ready), .overrun(ovr8),
`ifdef SIPO_PARITY_EN
        .parity_err(perr8),
`endif
        .bit_count(bc8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_in    = b;
        serial_valid = 1'b1;
        tick();
        serial_valid = 1'b0;
    endtask

    // first bit sent is word[n-1]; a correct even-parity bit follows in parity builds
    task automatic send_frame(input logic [7:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(word[i]);
        end
`ifdef SIPO_PARITY_EN
        send_bit(^word);
`endif
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        clear        = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        parallel_ready = 1'b1;
        do_reset();

        // reset state of every instance
        check_val("rst_out4",  64'(out4),   64'h0);
        check_val("rst_vld4",  64'(valid4), 64'h0);
        check_val("rst_ovr4",  64'(ovr4),   64'h0);
        check_val("rst_bc4",   64'(bc4),    64'h0);
        check_val("rst_out4l", 64'(out4l),  64'h0);
        check_val("rst_vld4l", 64'(valid4l), 64'h0);
        check_val("rst_ovr4l", 64'(ovr4l),  64'h0);
        check_val("rst_bc4l",  64'(bc4l),   64'h0);
        check_val("rst_out8",  64'(out8),   64'h0);
        check_val("rst_vld8",  64'(valid8), 64'h0);
        check_val("rst_ovr8",  64'(ovr8),   64'h0);
        check_val("rst_bc8",   64'(bc8),    64'h0);
`ifdef SIPO_PARITY_EN
        check_val("rst_perr4",  64'(perr4),  64'h0);
        check_val("rst_perr4l", 64'(perr4l), 64'h0);
        check_val("rst_perr8",  64'(perr8),  64'h0);
`endif

        // MSB-first / LSB-first with bit_count progression
        send_bit(1'b1); check_val("bc_1", 64'(bc4), 64'd1);
        send_bit(1'b0); check_val("bc_2", 64'(bc4), 64'd2);
        send_bit(1'b1); check_val("bc_3", 64'(bc4), 64'd3);
        send_bit(1'b1);
`ifdef SIPO_PARITY_EN
        check_val("bc_sat", 64'(bc4), 64'd3);
        check_val("vld_before_par", 64'(valid4), 64'h0);
        send_bit(1'b1);
`endif
        check_val("bc_wrap", 64'(bc4), 64'd0);
        check_val("msb_word", 64'(out4), 64'hB);
        check_val("msb_vld", 64'(valid4), 64'h1);
        check_val("lsb_word", 64'(out4l), 64'hD);
        tick();
        check_val("consumed_vld", 64'(valid4), 64'h0);
        check_val("consumed_hold", 64'(out4), 64'hB);

        // 8-bit MSB-first
        do_reset();
        send_frame(8'hA5, 8);
        check_val("w8_word", 64'(out8), 64'hA5);
        check_val("w8_vld", 64'(valid8), 64'h1);

        // overrun with ready low
        do_reset();
        parallel_ready = 1'b0;
        send_frame(8'h0B, 4);
        check_val("ovr_first_vld", 64'(valid4), 64'h1);
        check_val("ovr_first_no", 64'(ovr4), 64'h0);
        send_frame(8'h06, 4);
        check_val("ovr_pulse", 64'(ovr4), 64'h1);
        check_val("ovr_kept", 64'(out4), 64'hB);
        check_val("ovr_vld", 64'(valid4), 64'h1);
        tick();
        check_val("ovr_one_cyc", 64'(ovr4), 64'h0);
        parallel_ready = 1'b1;
        tick();
        check_val("ovr_drain", 64'(valid4), 64'h0);

        // ready high on the completion edge of the second frame
        do_reset();
        parallel_ready = 1'b0;
        send_frame(8'h0B, 4);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
`ifdef SIPO_PARITY_EN
        send_bit(1'b0);
`endif
        parallel_ready = 1'b1;
`ifdef SIPO_PARITY_EN
        send_bit(1'b0);
`else
        send_bit(1'b0);
`endif
        check_val("simul_word", 64'(out4), 64'h6);
        check_val("simul_no_ovr", 64'(ovr4), 64'h0);
        check_val("simul_vld", 64'(valid4), 64'h1);

        // gaps in serial_valid mid-frame
        do_reset();
        send_bit(1'b1);
        tick();
        check_val("gap_bc_hold", 64'(bc4), 64'd1);
        send_bit(1'b0);
        tick();
        tick();
        send_bit(1'b1);
        send_bit(1'b1);
`ifdef SIPO_PARITY_EN
        send_bit(1'b1);
`endif
        check_val("gap_word", 64'(out4), 64'hB);

        // clear beats a simultaneous serial bit
        do_reset();
        send_bit(1'b0);
        send_bit(1'b1);
        serial_in    = 1'b1;
        serial_valid = 1'b1;
        clear        = 1'b1;
        tick();
        clear        = 1'b0;
        serial_valid = 1'b0;
        check_val("clr_bc", 64'(bc4), 64'd0);
        check_val("clr_no_vld", 64'(valid4), 64'h0);
        send_frame(8'h0F, 4);
        check_val("clr_word", 64'(out4), 64'hF);

        // asynchronous reset mid-frame with a buffered word
        do_reset();
        parallel_ready = 1'b0;
        send_frame(8'h0B, 4);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        #2 rst = 1'b0;
        #1;
        check_val("arst_out", 64'(out4), 64'h0);
        check_val("arst_vld", 64'(valid4), 64'h0);
        check_val("arst_bc", 64'(bc4), 64'h0);
        check_val("arst_ovr", 64'(ovr4), 64'h0);
        #1 rst = 1'b1;
        parallel_ready = 1'b1;
        send_frame(8'h06, 4);
        check_val("arst_clean_word", 64'(out4), 64'h6);
        check_val("arst_clean_vld", 64'(valid4), 64'h1);

`ifdef SIPO_PARITY_EN
        // good and bad parity
        do_reset();
        send_frame(8'h0B, 4);
        check_val("par_ok", 64'(perr4), 64'h0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0);
        check_val("par_bad", 64'(perr4), 64'h1);
        check_val("par_bad_word", 64'(out4), 64'hB);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
